shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq.sv | 87 ++++++++
 tb/tb_shift_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Iterative 32-bit barrel shifter: one 2^k stage per cycle for k = 4..0.
// It supports SLL (zero fill) and SRA (sign fill), with a valid/ready handshake on each side.
module shift_seq #(
   parameter bit ZERO_FAST = 1'b0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_shamt,
   input  logic        in_op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [4:0]  shamt_q, shamt_d;
   logic        op_q, op_d;
   logic [31:0] work_q, work_d;
   logic [4:0]  stage_amt;

   assign stage_amt = 5'd1 << k_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         shamt_q <= '0;
         op_q    <= 1'b0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         shamt_q <= shamt_d;
         op_q    <= op_d;
         work_q  <= work_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      shamt_d = shamt_q;
      op_d    = op_q;
      work_d  = work_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_data;
               shamt_d = in_shamt;
               op_d    = in_op;
               // Zero-shift fast path: a single no-op stage gives result one cycle after accept
               k_d     = (ZERO_FAST && (in_shamt == '0)) ? 3'd0 : 3'd4;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (shamt_q[k_q]) begin
               if (op_q) work_d = $signed(work_q) >>> stage_amt;
               else      work_d = work_q << stage_amt;
            end
            if (k_q == '0) state_d = DONE;
            else           k_d = k_q - 3'd1;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = work_q;

endmodule

// File: tb/tb_shift_seq.sv
// Randomized self-checking bench for shift_seq: directed corner cases plus a sweep
// against a plain-arithmetic shift model; a second instance exercises ZERO_FAST=1.
module tb_shift_seq;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        in_valid, zf_in_valid;
   logic        in_ready, zf_in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shamt;
   logic        in_op;
   logic        out_valid, zf_out_valid;
   logic        out_ready;
   logic [31:0] out_data, zf_out_data;
   logic        busy, zf_busy;

   int unsigned errs   = 0;
   int unsigned checks = 0;

   shift_seq #(.ZERO_FAST(1'b0)) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   shift_seq #(.ZERO_FAST(1'b1)) dut_zf (
      .clock(clock), .reset_n(reset_n), .in_valid(zf_in_valid), .in_ready(zf_in_ready),
      .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .out_valid(zf_out_valid),
      .out_ready(out_ready), .out_data(zf_out_data), .busy(zf_busy)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d,
                                             input int unsigned s);
      if (!op)       return d << s;
      else if (d[31]) return ~((~d) >> s);
      else           return d >> s;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issues one request on the main instance and waits for out_valid (bounded).
   task automatic do_req(input logic op, input logic [31:0] d, input logic [4:0] s,
                         input bit noise, output int lat, output logic [31:0] res);
      int w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      in_op = op; in_data = d; in_shamt = s; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         if (noise) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            in_shamt = 5'($urandom);
            in_op    = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (out_valid) begin
            lat = c;
            break;
         end
      end
      in_valid = 1'b0;
      res = out_data;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (out_data !== 32'h0) begin errs++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1 || zf_in_ready !== 1'b1) begin errs++; $display("FAIL post_reset_ready got=%b/%b exp=1/1", in_ready, zf_in_ready); end
   endtask

   task automatic test_sll16();
      int lat;
      logic [31:0] res;
      do_req(1'b0, 32'h0000ABCD, 5'd16, 1'b0, lat, res);
      checks++; if (lat != 5) begin errs++; $display("FAIL sll16_latency got=%0d exp=5", lat); end
      checks++; if (res !== 32'hABCD0000) begin errs++; $display("FAIL sll16_data got=%h exp=abcd0000", res); end
      checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL sll16_ready_in_done got=%b exp=0", in_ready); end
      release_result();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL sll16_return_idle got ready=%b valid=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_sra();
      int lat;
      logic [31:0] res;
      do_req(1'b1, 32'h80000000, 5'd31, 1'b0, lat, res);
      checks++; if (res !== 32'hFFFFFFFF) begin errs++; $display("FAIL sra31_data got=%h exp=ffffffff", res); end
      checks++; if (lat != 5) begin errs++; $display("FAIL sra31_latency got=%0d exp=5", lat); end
      release_result();
      do_req(1'b1, 32'h7FFF0000, 5'd8, 1'b0, lat, res);
      checks++; if (res !== 32'h007FFF00) begin errs++; $display("FAIL sra8_data got=%h exp=007fff00", res); end
      release_result();
   endtask

   task automatic test_zero();
      int lat_m = -1;
      int lat_z = -1;
      in_op = 1'b0; in_data = 32'h00000001; in_shamt = 5'd0; out_ready = 1'b0;
      in_valid = 1'b1; zf_in_valid = 1'b1;
      tick();
      in_valid = 1'b0; zf_in_valid = 1'b0;
      in_data = 32'hDEADBEEF; in_shamt = 5'd7; in_op = 1'b1;
      checks++; if (zf_busy !== 1'b1) begin errs++; $display("FAIL zero_fast_busy got=%b exp=1", zf_busy); end
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (out_valid && lat_m < 0) lat_m = c;
         if (zf_out_valid && lat_z < 0) lat_z = c;
      end
      checks++; if (lat_m != 5) begin errs++; $display("FAIL zero_slow_latency got=%0d exp=5", lat_m); end
      checks++; if (lat_z != 1) begin errs++; $display("FAIL zero_fast_latency got=%0d exp=1", lat_z); end
      checks++; if (out_data !== 32'h1) begin errs++; $display("FAIL zero_slow_data got=%h exp=1", out_data); end
      checks++; if (zf_out_data !== 32'h1) begin errs++; $display("FAIL zero_fast_data got=%h exp=1", zf_out_data); end
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [31:0] res;
      logic [31:0] exp = ref_shift(1'b1, 32'h8000F000, 4);
      do_req(1'b1, 32'h8000F000, 5'd4, 1'b0, lat, res);
      checks++; if (res !== exp) begin errs++; $display("FAIL bp_data got=%h exp=%h", res, exp); end
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1; in_data = $urandom; in_shamt = 5'($urandom); in_op = 1'($urandom);
         tick();
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
            errs++;
            $display("FAIL bp_stall%0d got valid=%b ready=%b data=%h exp 1/0/%h", c, out_valid, in_ready, out_data, exp);
         end
      end
      in_valid = 1'b0;
      release_result();
      checks++; if (in_ready !== 1'b1 || out_data !== exp) begin errs++; $display("FAIL bp_after got ready=%b data=%h exp 1/%h", in_ready, out_data, exp); end
   endtask

   task automatic test_reset_mid();
      int lat;
      logic [31:0] res;
      bit seen = 1'b0;
      in_op = 1'b0; in_data = 32'h0000FFFF; in_shamt = 5'd3; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0) begin
         errs++;
         $display("FAIL mid_reset got ready=%b valid=%b busy=%b data=%h exp 1/0/0/0", in_ready, out_valid, busy, out_data);
      end
      #3 reset_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen) begin errs++; $display("FAIL mid_reset_no_valid got=1 exp=0"); end
      do_req(1'b0, 32'h1, 5'd31, 1'b0, lat, res);
      checks++; if (res !== 32'h80000000 || lat != 5) begin errs++; $display("FAIL mid_reset_next got=%h lat=%0d exp=80000000 lat=5", res, lat); end
      release_result();
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] res, d, exp;
      logic [4:0]  s;
      logic        op;
      int unsigned stall;
      for (int n = 0; n < 1000; n++) begin
         d = $urandom; s = 5'($urandom); op = 1'($urandom);
         exp = ref_shift(op, d, s);
         do_req(op, d, s, 1'b1, lat, res);
         checks++; if (lat != 5) begin errs++; $display("FAIL rnd%0d_latency got=%0d exp=5", n, lat); end
         checks++; if (res !== exp) begin errs++; $display("FAIL rnd%0d_data op=%b d=%h s=%0d got=%h exp=%h", n, op, d, s, res, exp); end
         stall = $urandom_range(0, 3);
         for (int unsigned c = 0; c < stall; c++) begin
            in_valid = 1'($urandom); in_data = $urandom;
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errs++; $display("FAIL rnd%0d_hold got valid=%b data=%h exp 1/%h", n, out_valid, out_data, exp); end
         end
         in_valid = 1'b0;
         release_result();
         checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rnd%0d_idle got=%b exp=1", n, in_ready); end
      end
   endtask

   initial begin
      in_valid = 1'b0; zf_in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_shamt = '0; in_op = 1'b0;
      test_reset();
      test_sll16();
      test_sra();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
